// File: rtl/f_d_reg.sv
// Fetch-to-decode pipeline register: latches IR/PC/PC+8/delay-slot flag, flags
// misaligned or out-of-range fetch addresses as AdEL, supports stall and flush.
module f_d_reg #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          IM_WORDS = 1024,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             flush,
  input  logic [31:0]      IR_F,
  input  logic [31:0]      PC_F,
  input  logic             BD_F,
  output logic [31:0]      IR_D,
  output logic [31:0]      PC_D,
  output logic [31:0]      PC8_D,
  output logic             BD_D,
  output logic [4:0]       EXC_D,
  output logic             valid_D,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [31:0] LAST_PC  = RESET_PC + 32'(4 * IM_WORDS) - 32'd4;
  localparam logic [4:0]  EXC_NONE = 5'd0;
  localparam logic [4:0]  EXC_ADEL = 5'd4;

  logic fault;

  // Unsigned compares; a faulting fetch loads a zero word so X on IR_F never reaches D.
  always_comb begin
    fault = 1'b0;
    if (PC_F[1:0] != 2'b00) fault = 1'b1;
    if (PC_F < RESET_PC)    fault = 1'b1;
    if (PC_F > LAST_PC)     fault = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      IR_D      <= 32'd0;
      PC_D      <= RESET_PC;
      PC8_D     <= RESET_PC + 32'd8;
      BD_D      <= 1'b0;
      EXC_D     <= EXC_NONE;
      valid_D   <= 1'b0;
      stall_cnt <= '0;
    end else if (flush) begin
      // Bubble keeps PC_F so EPC tracking downstream still sees a sensible PC.
      IR_D    <= 32'd0;
      PC_D    <= PC_F;
      PC8_D   <= PC_F + 32'd8;
      BD_D    <= 1'b0;
      EXC_D   <= EXC_NONE;
      valid_D <= 1'b0;
    end else if (en) begin
      IR_D    <= fault ? 32'd0 : IR_F;
      PC_D    <= PC_F;
      PC8_D   <= PC_F + 32'd8;
      BD_D    <= BD_F;
      EXC_D   <= fault ? EXC_ADEL : EXC_NONE;
      valid_D <= 1'b1;
    end else if (stall_cnt != {CNT_W{1'b1}}) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: doc/f_d_reg.md
Name: f_d_reg

Overview:
- Fetch-to-decode pipeline register. It sits directly downstream of the PC/instruction-memory/PC+4 fetch logic and feeds the D stage.
- Latches the fetched instruction word, its PC, PC+8 (link value) and the delay-slot flag.
- Detects fetch address exceptions (AdEL) and carries the exception code into D.
- Supports stall (hold) and flush (insert bubble).
- Keeps a saturating stall-cycle counter for performance debug.

Parameters:
- RESET_PC, 32'h00003000, PC value loaded into PC_D at reset; also the base of the legal instruction range.
- IM_WORDS, 1024, number of instruction-memory words. Legal fetch range is RESET_PC to RESET_PC+4*IM_WORDS-4 inclusive.
- CNT_W, 16, width of the stall counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset; reset==0 at a rising clk edge resets all state.
- en  input  1  1 = advance (load F values); 0 = stall (hold).
- flush  input  1  1 = load a bubble (exception/eret); takes priority over en.
- IR_F  input  32  instruction word from instruction memory.
- PC_F  input  32  current fetch PC.
- BD_F  input  1  instruction in F occupies a branch delay slot.
- IR_D  output  32  latched instruction.
- PC_D  output  32  latched PC.
- PC8_D  output  32  latched PC+8.
- BD_D  output  1  latched delay-slot flag.
- EXC_D  output  5  exception code: 0 = none, 4 = AdEL.
- valid_D  output  1  1 = D holds a real fetched instruction (possibly faulting); 0 = bubble.
- stall_cnt  output  CNT_W  count of stall cycles.

Behaviour:
- All outputs are registered. Latency is 1 cycle from F inputs to D outputs. There is no combinational path from inputs to outputs.

Priority per rising edge: reset==0, then flush, then en, then hold.

Reset values:
- IR_D=0, PC_D=RESET_PC, PC8_D=RESET_PC+8.
- BD_D=0, EXC_D=0, valid_D=0, stall_cnt=0.
- Reset asserted mid-stream discards the held instruction in the same edge.

Flush (reset==1, flush==1), regardless of en:
- IR_D=0 (nop), PC_D=PC_F, PC8_D=PC_F+8.
- BD_D=0, EXC_D=0, valid_D=0.
- The bubble carries PC_F so downstream macro-PC/EPC tracking stays meaningful.
- stall_cnt is unchanged.

Advance (reset==1, flush==0, en==1):
- PC_D=PC_F, PC8_D=PC_F+8 (mod 2^32, wrap-around permitted), BD_D=BD_F, valid_D=1.
- Fault condition:
  - fault = (PC_F[1:0]!=0), or
  - fault = (PC_F < RESET_PC), or
  - fault = (PC_F > RESET_PC+4*IM_WORDS-4).
  - Use unsigned 32-bit comparison.
- On fault: IR_D=0 and EXC_D=4. The faulting instruction never decodes as a real opcode.
- On no fault: IR_D=IR_F and EXC_D=0.

Stall (reset==1, flush==0, en==0):
- All D outputs hold their values.
- stall_cnt increments by 1 and saturates at 2^CNT_W-1 (no wrap).

Simultaneous events:
- flush and en==0 in the same cycle: the flush wins, and the cycle is not counted as a stall.
- reset==0 overrides everything.

Unknown inputs:
- X on IR_F must not propagate into IR_D when a fault is detected, because IR_D is forced to 0.

Test Plan:
- Reset, then hold reset=0 for 2 cycles -> IR_D=0, PC_D=0x3000, PC8_D=0x3008, valid_D=0, EXC_D=0, stall_cnt=0.
- en=1, PC_F=0x3004, IR_F=0x24080005, BD_F=1 -> after 1 edge: IR_D=0x24080005, PC_D=0x3004, PC8_D=0x300C, BD_D=1, valid_D=1, EXC_D=0.
- Load as above, then en=0 for 3 cycles while PC_F/IR_F change -> D outputs unchanged, stall_cnt=3. Then en=0 together with flush=1, PC_F=0x3010 -> IR_D=0, PC_D=0x3010, valid_D=0, stall_cnt still 3.
- en=1 with PC_F=0x3002 -> EXC_D=4, IR_D=0, valid_D=1. Then PC_F=0x4000 -> EXC_D=4. Then PC_F=0x3FFC -> EXC_D=0, IR_D=IR_F. Then PC_F=0x2FFC -> EXC_D=4.
- With CNT_W=4, hold en=0 for 20 cycles -> stall_cnt reaches 15 and stays at 15.
- Drive reset=0 for one edge in the middle of a stall with valid_D=1 -> every output returns to its reset value on that edge, including stall_cnt=0. The first advance after reset loads normally.
